mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates the single shared program/data memory between the instruction-fetch path (pc_reg → op register) and the load/store data path (cmd[3] store, load_num into DATA_MUX). Sequences each access over a fixed number of memory cycles, drives the memory's load/store controls, and returns read data with a one-cycle ready pulse. Raises stall so the pc/op registers freeze while a fetch waits behind a data access.

Parameters:
MEM_LAT, 2, memory access length in clk cycles (legal range 1..15)
STARVE_MAX, 2, maximum consecutive data grants while a fetch is pending (legal range 1..7)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request, level
if_addr  in  16  fetch address
if_ready  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  16  fetched instruction word
dm_req  in  1  data request, level
dm_we  in  1  1 = store, 0 = load
dm_addr  in  16  data address
dm_wdata  in  8  store data
dm_ready  out  1  one-cycle pulse; load data valid or store complete
dm_rdata  out  8  load data
mem_addr  out  16  memory address
mem_load_n  out  1  memory read enable, active low
mem_store  out  1  memory write enable, active high
mem_wdata  out  8  memory write data
mem_rdata  in  16  memory read data
stall  out  1  combinational: if_req & ~if_ready

Behaviour:
- Reset state is IDLE. All registered outputs reset as follows: mem_addr=0, mem_load_n=1, mem_store=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0, starvation counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: choose a winner, register winner/addr/we/wdata, load cnt=MEM_LAT-1, go to ACCESS.
- Winner rule:
  - Only one requester: it wins.
  - Both requesting: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
- Starvation counter:
  - Increments on a data grant while if_req=1.
  - Clears on any fetch grant, or on a data grant while if_req=0.
  - Saturates at STARVE_MAX.
- ACCESS:
  - mem_addr = latched address.
  - Fetch or load: mem_load_n=0.
  - Store: mem_store=1, mem_wdata = latched wdata.
  - Each cycle: cnt decrements.
  - When cnt==0: capture mem_rdata (fetch → if_rdata; load → dm_rdata = mem_rdata[7:0]; store → no capture), go to RESP.
- RESP:
  - Memory controls idle (mem_load_n=1, mem_store=0).
  - The winner's ready is high for exactly this cycle.
  - Next state is IDLE.
- Timing: a request sampled in IDLE at cycle T sees ready in cycle T+MEM_LAT+1. Memory is busy for cycles T+1..T+MEM_LAT. Minimum request-to-request spacing is MEM_LAT+2 cycles.
- Handshake:
  - Requester holds req/addr/we/wdata stable until it sees ready.
  - In the cycle after ready, req=1 is a new request.
  - Dropping req while granted does not abort the access.
- Captured rdata holds its value until the next capture of the same type.
- Reset mid-ACCESS or mid-RESP: the access is abandoned. In the next cycle all reset values apply and no ready is issued.
- if_ready and dm_ready are never high in the same cycle.
- Parameter values outside the legal range are a fatal elaboration error.

Decomposition:
- Shared package mem_arb_pkg holds:
  - ADDR_W=16, INSTR_W=16, DATA_W=8.
  - typedef enum arb_state_t {IDLE, ACCESS, RESP}.
  - typedef enum owner_t {OWN_FETCH, OWN_DATA}.
- One sub-module, mem_arb_fair, implements the starvation counter and the winner-select logic. Inputs: clk, rst, if_req, dm_req, grant strobe. Outputs: fetch_wins.

Test Plan:
1. MEM_LAT=2, fetch only, if_addr=0x0010, mem_rdata=0xA5C3 → mem_load_n=0 in T+1..T+2; if_ready=1 only in T+3; if_rdata=0xA5C3; stall=1 in T..T+2.
2. MEM_LAT=2, simultaneous if_req (0x0004) and store dm_addr=0x0020 dm_wdata=0x5A → mem_store=1 with mem_addr=0x0020 and mem_wdata=0x5A in T+1..T+2; dm_ready in T+3; fetch granted at T+4; if_ready in T+7.
3. STARVE_MAX=2, if_req and dm_req held high continuously → grant order D,D,F,D,D,F; if_ready and dm_ready never coincide.
4. Load dm_addr=0x0031, mem_rdata=0x12F7 → dm_rdata=0xF7 at dm_ready; if_rdata unchanged.
5. rst=1 during the second ACCESS cycle of a fetch → next cycle: mem_load_n=1, if_ready=0 then and afterwards, if_rdata=0, state IDLE.
6. MEM_LAT=1, back-to-back fetches with if_req held high and addresses 0,1,2 → if_ready every 3 cycles; mem_addr sequence 0,1,2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and state/owner types for the memory port arbiter
package mem_arb_pkg;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int DATA_W  = 8;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;
endpackage

// File: rtl/mem_arb_fair.sv
// mem_arb_fair: winner select with a starvation counter that forces a fetch grant after STARVE_MAX data grants
module mem_arb_fair #(
    parameter int STARVE_MAX = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic dm_req,
    input  logic grant,
    output logic fetch_wins
);
    logic [2:0] r_starve;
    logic       w_sat;
    assign w_sat      = r_starve == 3'(STARVE_MAX);
    assign fetch_wins = if_req & (~dm_req | w_sat);
    // count data grants taken while a fetch waits; any fetch grant or uncontested data grant clears it
    always_ff @(posedge clk) begin
        if (rst)
            r_starve <= '0;
        else if (grant)
            r_starve <= (fetch_wins | ~if_req) ? '0 : w_sat ? r_starve : r_starve + 3'd1;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between instruction fetch and load/store with fixed-length accesses
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic               if_ready,
    output logic [INSTR_W-1:0] if_rdata,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [ADDR_W-1:0]  dm_addr,
    input  logic [DATA_W-1:0]  dm_wdata,
    output logic               dm_ready,
    output logic [DATA_W-1:0]  dm_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_load_n,
    output logic               mem_store,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               stall
);
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $fatal(1, "mem_port_arbiter: MEM_LAT must be 1..15");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve
        $fatal(1, "mem_port_arbiter: STARVE_MAX must be 1..7");
    end

    arb_state_t         r_state;
    owner_t             r_owner;
    logic [3:0]         r_cnt;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_load_n;
    logic               r_mem_store;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic               r_if_ready;
    logic               r_dm_ready;
    logic [INSTR_W-1:0] r_if_rdata;
    logic [DATA_W-1:0]  r_dm_rdata;
    logic               w_grant;
    logic               w_fetch_wins;
    logic               w_store;

    assign w_grant = (r_state == IDLE) & (if_req | dm_req);
    assign w_store = ~w_fetch_wins & dm_we;

    mem_arb_fair #(.STARVE_MAX(STARVE_MAX)) u_fair (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .dm_req     (dm_req),
        .grant      (w_grant),
        .fetch_wins (w_fetch_wins)
    );

    // grant in IDLE, hold memory controls for MEM_LAT cycles, then pulse the winner's ready for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_FETCH;
            r_cnt        <= '0;
            r_mem_addr   <= '0;
            r_mem_load_n <= 1'b1;
            r_mem_store  <= 1'b0;
            r_mem_wdata  <= '0;
            r_if_ready   <= 1'b0;
            r_dm_ready   <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_grant) begin
                    r_state      <= ACCESS;
                    r_cnt        <= 4'(MEM_LAT - 1);
                    r_owner      <= w_fetch_wins ? OWN_FETCH : OWN_DATA;
                    r_mem_addr   <= w_fetch_wins ? if_addr : dm_addr;
                    r_mem_load_n <= w_store;
                    r_mem_store  <= w_store;
                    if (w_store) r_mem_wdata <= dm_wdata;
                end
                ACCESS: if (r_cnt == 4'd0) begin
                    r_state      <= RESP;
                    r_mem_load_n <= 1'b1;
                    r_mem_store  <= 1'b0;
                    if (r_owner == OWN_FETCH) begin
                        r_if_ready <= 1'b1;
                        r_if_rdata <= mem_rdata;
                    end else begin
                        r_dm_ready <= 1'b1;
                        if (!r_mem_store) r_dm_rdata <= mem_rdata[DATA_W-1:0];
                    end
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                RESP: begin
                    r_state    <= IDLE;
                    r_if_ready <= 1'b0;
                    r_dm_ready <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_load_n = r_mem_load_n;
    assign mem_store  = r_mem_store;
    assign mem_wdata  = r_mem_wdata;
    assign if_ready   = r_if_ready;
    assign dm_ready   = r_dm_ready;
    assign if_rdata   = r_if_rdata;
    assign dm_rdata   = r_dm_rdata;
    assign stall      = if_req & ~r_if_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed steps with a response scoreboard for the memory port arbiter
module tb_mem_port_arbiter;
    typedef struct packed {
        logic        f;
        logic        cd;
        logic [15:0] d;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr;
    logic [7:0]  dm_wdata;
    logic        if_ready, dm_ready, mem_load_n, mem_store, stall;
    logic [15:0] if_rdata, mem_addr, mem_rdata;
    logic [7:0]  dm_rdata, mem_wdata;
    logic        if_req1, if_ready1, dm_ready1, mem_load_n1, mem_store1, stall1;
    logic [15:0] if_addr1, if_rdata1, mem_addr1, mem_rdata1;
    logic [7:0]  dm_rdata1, mem_wdata1;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_rdy = 0;
    exp_t q[$];
    exp_t q1[$];

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return a == 16'h0010 ? 16'hA5C3 : a == 16'h0031 ? 16'h12F7 : 16'h3C00 ^ {a[7:0], ~a[7:0]};
    endfunction

    assign mem_rdata  = mem_f(mem_addr);
    assign mem_rdata1 = mem_f(mem_addr1);

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_load_n(mem_load_n), .mem_store(mem_store),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1), .if_rdata(if_rdata1),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(16'h0000), .dm_wdata(8'h00),
        .dm_ready(dm_ready1), .dm_rdata(dm_rdata1),
        .mem_addr(mem_addr1), .mem_load_n(mem_load_n1), .mem_store(mem_store1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .stall(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] x);
        n_vec++;
        assert (o === x) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", t, o, x);
        end
    endtask

    // advance to the next falling edge and score any ready pulse against the queues
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (if_ready | dm_ready) begin
            n_rdy++;
            chk("ready_excl", 32'(if_ready & dm_ready), 32'd0);
            if (q.size() == 0) begin
                chk("sb_unexpected", 32'({if_ready, dm_ready}), 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_owner", 32'({if_ready, dm_ready}), e.f ? 32'd2 : 32'd1);
                if (e.cd) chk("sb_data", if_ready ? 32'(if_rdata) : 32'(dm_rdata), 32'(e.d));
            end
        end
        if (if_ready1) begin
            if (q1.size() == 0) begin
                chk("sb1_unexpected", 32'(if_ready1), 32'd0);
            end else begin
                e = q1.pop_front();
                chk("sb1_data", 32'(if_rdata1), 32'(e.d));
            end
        end
    endtask

    initial begin
        logic [15:0] t;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        if_req1 = 1'b0; if_addr1 = '0;
        repeat (2) cyc();
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_load_n", 32'(mem_load_n), 32'd1);
        chk("rst_store", 32'(mem_store), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_readies", 32'({if_ready, dm_ready}), 32'd0);
        chk("rst_if_rdata", 32'(if_rdata), 32'd0);
        chk("rst_dm_rdata", 32'(dm_rdata), 32'd0);
        rst = 1'b0;
        cyc();

        // fetch only, MEM_LAT=2
        if_req = 1'b1; if_addr = 16'h0010;
        q.push_back('{f: 1'b1, cd: 1'b1, d: 16'hA5C3});
        #1 chk("t1_stall_T", 32'(stall), 32'd1);
        cyc();
        chk("t1_load_n_T1", 32'(mem_load_n), 32'd0);
        chk("t1_addr_T1", 32'(mem_addr), 32'h10);
        chk("t1_ready_T1", 32'(if_ready), 32'd0);
        chk("t1_stall_T1", 32'(stall), 32'd1);
        cyc();
        chk("t1_load_n_T2", 32'(mem_load_n), 32'd0);
        chk("t1_ready_T2", 32'(if_ready), 32'd0);
        chk("t1_stall_T2", 32'(stall), 32'd1);
        cyc();
        chk("t1_ready_T3", 32'(if_ready), 32'd1);
        chk("t1_load_n_T3", 32'(mem_load_n), 32'd1);
        chk("t1_stall_T3", 32'(stall), 32'd0);
        if_req = 1'b0;
        cyc();
        chk("t1_ready_T4", 32'(if_ready), 32'd0);
        chk("t1_rdata_hold", 32'(if_rdata), 32'hA5C3);

        // simultaneous fetch and store: data first, fetch granted right after
        if_req = 1'b1; if_addr = 16'h0004;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0020; dm_wdata = 8'h5A;
        q.push_back('{f: 1'b0, cd: 1'b0, d: 16'h0000});
        q.push_back('{f: 1'b1, cd: 1'b1, d: mem_f(16'h0004)});
        for (int k = 1; k <= 2; k++) begin
            cyc();
            chk("t2_store", 32'(mem_store), 32'd1);
            chk("t2_addr", 32'(mem_addr), 32'h20);
            chk("t2_wdata", 32'(mem_wdata), 32'h5A);
            chk("t2_load_n", 32'(mem_load_n), 32'd1);
        end
        cyc();
        chk("t2_dm_ready_T3", 32'(dm_ready), 32'd1);
        chk("t2_store_T3", 32'(mem_store), 32'd0);
        dm_req = 1'b0; dm_we = 1'b0;
        cyc();
        chk("t2_stall_T4", 32'(stall), 32'd1);
        chk("t2_dm_ready_T4", 32'(dm_ready), 32'd0);
        cyc();
        chk("t2_fetch_load_n_T5", 32'(mem_load_n), 32'd0);
        chk("t2_fetch_addr_T5", 32'(mem_addr), 32'h4);
        cyc();
        chk("t2_if_ready_T6", 32'(if_ready), 32'd0);
        cyc();
        chk("t2_if_ready_T7", 32'(if_ready), 32'd1);
        if_req = 1'b0;
        cyc();

        // load keeps if_rdata and returns the low byte
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0031;
        q.push_back('{f: 1'b0, cd: 1'b1, d: 16'h00F7});
        cyc();
        chk("t4_load_n", 32'(mem_load_n), 32'd0);
        chk("t4_store", 32'(mem_store), 32'd0);
        cyc();
        cyc();
        chk("t4_dm_ready", 32'(dm_ready), 32'd1);
        chk("t4_if_rdata_kept", 32'(if_rdata), 32'(mem_f(16'h0004)));
        dm_req = 1'b0;
        cyc();

        // both held continuously: grant order D,D,F,D,D,F
        if_req = 1'b1; if_addr = 16'h000C;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0008;
        t = mem_f(16'h0008);
        for (int n = 0; n < 6; n++)
            q.push_back(n % 3 == 2 ? exp_t'{f: 1'b1, cd: 1'b1, d: mem_f(16'h000C)}
                                   : exp_t'{f: 1'b0, cd: 1'b1, d: {8'h00, t[7:0]}});
        n_rdy = 0;
        for (int k = 0; k < 60 && n_rdy < 6; k++) cyc();
        if_req = 1'b0; dm_req = 1'b0;
        chk("t3_grants", 32'(n_rdy), 32'd6);
        chk("t3_sb_empty", 32'(q.size()), 32'd0);
        cyc();

        // reset during the second ACCESS cycle of a fetch
        if_req = 1'b1; if_addr = 16'h0010;
        cyc();
        chk("t5_load_n_T1", 32'(mem_load_n), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("t5_load_n", 32'(mem_load_n), 32'd1);
        chk("t5_if_ready", 32'(if_ready), 32'd0);
        chk("t5_if_rdata", 32'(if_rdata), 32'd0);
        chk("t5_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0; if_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t5_no_ready", 32'(if_ready), 32'd0);
            chk("t5_idle_load_n", 32'(mem_load_n), 32'd1);
        end

        // MEM_LAT=1 back-to-back fetches
        if_req1 = 1'b1; if_addr1 = 16'h0000;
        for (int a = 0; a < 3; a++) q1.push_back('{f: 1'b1, cd: 1'b1, d: mem_f(16'(a))});
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("t6_ready_cadence", 32'(if_ready1), 32'(k % 3 == 2));
            if (k % 3 == 1) begin
                chk("t6_mem_addr", 32'(mem_addr1), 32'(k / 3));
                chk("t6_load_n", 32'(mem_load_n1), 32'd0);
            end
            if (k % 3 == 2) if_addr1 = 16'(k / 3 + 1);
            if (k == 8) if_req1 = 1'b0;
        end
        cyc();
        chk("t6_sb_empty", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
